spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//   SPI mode-0 (CPOL=0, CPHA=0) bus master: host-side counterpart of the SPI slave.
//   Serialises bytes MSb-first on MOSI, drives SCK and an active-low chip-select, and samples MISO.
//   Takes bytes through a valid/ready handshake in the i_sys_clk domain.
//   Groups bytes into CS-framed bursts with programmable CS setup/hold/idle times.
//   Used to drive slave-side SPI blocks and external SPI peripherals from FPGA logic.
// PARAMETERS
//   CLKS_PER_HALF_BIT  4  i_sys_clk cycles per SCK half-period (legal >=2)
//   CS_SETUP_CLKS      4  cycles from CS_b fall to first SCK rise (>=1)
//   CS_HOLD_CLKS       4  cycles from last SCK fall to CS_b rise (>=1)
//   CS_IDLE_CLKS       8  minimum CS_b high time before next burst may start (>=1)
// PORTS
//   i_sys_clk        in   1  system clock; single clock domain
//   i_rst_b          in   1  reset; asynchronous assert, active-low
//   i_tx_data_valid  in   1  byte offered; accepted when high with o_tx_ready high
//   i_tx_byte        in   8  byte to send, sampled on accept
//   i_tx_last        in   1  sampled on accept; 1 = this byte ends the CS burst
//   o_tx_ready       out  1  block can accept a byte this cycle
//   o_rx_data_valid  out  1  one-cycle pulse; o_rx_byte valid
//   o_rx_byte        out  8  byte shifted in from MISO, held until next pulse
//   o_busy           out  1  high whenever state != IDLE
//   o_spi_sck        out  1  SPI clock, idles low
//   o_spi_mosi       out  1  SPI data out
//   i_spi_miso       in   1  SPI data in
//   o_spi_cs_b       out  1  chip select, active-low
// BEHAVIOUR
//   Reset values:
//     sck=0, mosi=0, cs_b=1, tx_ready=0, rx_valid=0, rx_byte=0, busy=0, state=IDLE.
//     All outputs are registered.
//     tx_ready rises on the first clock edge after reset release.
//   FSM states: IDLE, SETUP, SHIFT, GAP, HOLD, CSIDLE.
//     IDLE:   tx_ready=1. Accept (cycle A) -> SETUP.
//             At A+1: cs_b=0, mosi=byte[7], ready=0.
//     SETUP:  hold sck low for CS_SETUP_CLKS cycles -> SHIFT.
//     SHIFT:  first SCK rise at A+1+CS_SETUP_CLKS; after that, an edge every CLKS_PER_HALF_BIT.
//             Exactly 8 rising and 8 falling edges per byte.
//             Rise: shift i_spi_miso into rx register (MSb first).
//             Fall 1..7: drive next MOSI bit. Fall 8: mosi holds bit0.
//             Cycle after fall 8: rx_valid=1 for one cycle and rx_byte updates.
//             Same cycle: last byte -> HOLD, otherwise -> GAP with tx_ready=1.
//     GAP:    cs_b stays low and sck stays low, for as long as needed.
//             Accept -> mosi=byte[7] next cycle; first rise CLKS_PER_HALF_BIT cycles later -> SHIFT.
//     HOLD:   after CS_HOLD_CLKS cycles measured from fall 8, cs_b=1 -> CSIDLE.
//     CSIDLE: cs_b=1 for CS_IDLE_CLKS cycles -> IDLE.
//             tx_ready=1 on the cycle IDLE is entered.
//   Handshake rules:
//     i_tx_data_valid is ignored while tx_ready=0; no queuing.
//     i_tx_byte and i_tx_last are sampled only on accept.
//   Counters: half-bit counter wraps at CLKS_PER_HALF_BIT-1; edge counter 0..15.
//     Widths are $clog2 of the maximum count, and no counter overflows.
//   Reset mid-burst:
//     Immediate (async) cs_b=1, sck=0; partial rx byte discarded; no rx_valid pulse.
//   Valid and last asserted in the same accept: single-byte burst.
//   GAP never times out; CS remains asserted until a byte with i_tx_last=1 completes.
// TESTING (CLKS_PER_HALF_BIT=2, CS_SETUP=2, CS_HOLD=2, CS_IDLE=4; MISO looped to MOSI)
//   1. 0xA5 with last=1, accepted at cycle A:
//        cs_b low at A+1, 8 SCK pulses, rx_valid at A+34 with rx_byte=0xA5,
//        cs_b high at A+35, ready at A+39.
//   2. Burst 0x01,0x80,0xFF (last on 0xFF), each offered as soon as ready:
//        cs_b low throughout, 24 SCK rises, rx bytes 0x01,0x80,0xFF in order, one cs_b rise.
//   3. MISO tied 0, MOSI byte 0xFF -> rx_byte=0x00.
//      MISO tied 1 -> rx_byte=0xFF.
//      Check MOSI is stable at every SCK rise.
//   4. Hold tx_data_valid high during SHIFT/HOLD/CSIDLE:
//        no extra accept; the next accept occurs only when ready=1 in IDLE.
//   5. Non-last byte, then 20 idle cycles before the next byte:
//        cs_b stays low, sck stays low in GAP, second byte shifts correctly.
//   6. Assert i_rst_b low after the 3rd SCK rise:
//        cs_b=1 and sck=0 asynchronously, no rx_valid;
//        after release, a new 0x3C transfer completes normally.

Source files
------------

// File: rtl/spi_master.sv
// SPI mode-0 bus master: serialises bytes MSb-first on MOSI, samples MISO on SCK rise,
// and frames byte bursts with an active-low chip select with programmable setup/hold/idle.
module spi_master #(
    parameter int CLKS_PER_HALF_BIT = 4,
    parameter int CS_SETUP_CLKS     = 4,
    parameter int CS_HOLD_CLKS      = 4,
    parameter int CS_IDLE_CLKS      = 8
) (
    input  logic       i_sys_clk,
    input  logic       i_rst_b,
    input  logic       i_tx_data_valid,
    input  logic [7:0] i_tx_byte,
    input  logic       i_tx_last,
    output logic       o_tx_ready,
    output logic       o_rx_data_valid,
    output logic [7:0] o_rx_byte,
    output logic       o_busy,
    output logic       o_spi_sck,
    output logic       o_spi_mosi,
    input  logic       i_spi_miso,
    output logic       o_spi_cs_b
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_CSIDLE = 3'd5;

    localparam int MAX_WAIT_A = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
    localparam int MAX_WAIT   = (MAX_WAIT_A > CS_IDLE_CLKS) ? MAX_WAIT_A : CS_IDLE_CLKS;
    localparam int WAIT_W     = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam int HALF_W     = $clog2(CLKS_PER_HALF_BIT);

    localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(CS_SETUP_CLKS - 1);
    localparam logic [WAIT_W-1:0] IDLE_LAST  = WAIT_W'(CS_IDLE_CLKS - 1);
    // The HOLD state is entered one cycle after fall 8, so it waits two cycles fewer.
    localparam logic [WAIT_W-1:0] HOLD_LAST  = (CS_HOLD_CLKS >= 2) ? WAIT_W'(CS_HOLD_CLKS - 2) : '0;
    localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(CLKS_PER_HALF_BIT - 1);

    logic [2:0]        r_state;
    logic [WAIT_W-1:0] r_waitCnt;
    logic [HALF_W-1:0] r_halfCnt;
    logic [3:0]        r_edgeCnt;
    logic [6:0]        r_txShift;
    logic [7:0]        r_rxShift;
    logic              r_last;
    logic              r_txReady;
    logic              r_rxValid;
    logic [7:0]        r_rxByte;
    logic              r_busy;
    logic              r_sck;
    logic              r_mosi;
    logic              r_csB;

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_state   <= S_IDLE;
            r_waitCnt <= '0;
            r_halfCnt <= '0;
            r_edgeCnt <= '0;
            r_txShift <= '0;
            r_rxShift <= '0;
            r_last    <= 1'b0;
            r_txReady <= 1'b0;
            r_rxValid <= 1'b0;
            r_rxByte  <= '0;
            r_busy    <= 1'b0;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_csB     <= 1'b1;
        end else begin
            r_rxValid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_txReady) begin
                        r_txReady <= 1'b1;
                    end else if (i_tx_data_valid) begin
                        r_txReady <= 1'b0;
                        r_csB     <= 1'b0;
                        r_mosi    <= i_tx_byte[7];
                        r_txShift <= i_tx_byte[6:0];
                        r_last    <= i_tx_last;
                        r_waitCnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_waitCnt == SETUP_LAST) begin
                        r_sck     <= 1'b1;
                        r_rxShift <= {r_rxShift[6:0], i_spi_miso};
                        r_halfCnt <= '0;
                        r_edgeCnt <= '0;
                        r_state   <= S_SHIFT;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    // Edge 15 is fall 8; the byte is complete on the cycle after it.
                    if (r_edgeCnt == 4'd15) begin
                        r_rxValid <= 1'b1;
                        r_rxByte  <= r_rxShift;
                        r_waitCnt <= '0;
                        if (!r_last) begin
                            r_txReady <= 1'b1;
                            r_state   <= S_GAP;
                        end else if (CS_HOLD_CLKS == 1) begin
                            r_csB   <= 1'b1;
                            r_state <= S_CSIDLE;
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end else if (r_halfCnt == HALF_LAST) begin
                        r_halfCnt <= '0;
                        r_edgeCnt <= r_edgeCnt + 1'b1;
                        if (r_edgeCnt[0]) begin
                            r_sck     <= 1'b1;
                            r_rxShift <= {r_rxShift[6:0], i_spi_miso};
                        end else begin
                            r_sck <= 1'b0;
                            if (r_edgeCnt != 4'd14) begin
                                r_mosi    <= r_txShift[6];
                                r_txShift <= {r_txShift[5:0], 1'b0};
                            end
                        end
                    end else begin
                        r_halfCnt <= r_halfCnt + 1'b1;
                    end
                end
                S_GAP: begin
                    // Ready low inside GAP means a byte was taken and its first rise is pending.
                    if (!r_txReady) begin
                        if (r_halfCnt == HALF_LAST) begin
                            r_sck     <= 1'b1;
                            r_rxShift <= {r_rxShift[6:0], i_spi_miso};
                            r_halfCnt <= '0;
                            r_edgeCnt <= '0;
                            r_state   <= S_SHIFT;
                        end else begin
                            r_halfCnt <= r_halfCnt + 1'b1;
                        end
                    end else if (i_tx_data_valid) begin
                        r_txReady <= 1'b0;
                        r_mosi    <= i_tx_byte[7];
                        r_txShift <= i_tx_byte[6:0];
                        r_last    <= i_tx_last;
                        r_halfCnt <= '0;
                    end
                end
                S_HOLD: begin
                    if (r_waitCnt == HOLD_LAST) begin
                        r_csB     <= 1'b1;
                        r_waitCnt <= '0;
                        r_state   <= S_CSIDLE;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                S_CSIDLE: begin
                    if (r_waitCnt == IDLE_LAST) begin
                        r_txReady <= 1'b1;
                        r_busy    <= 1'b0;
                        r_waitCnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_csB   <= 1'b1;
                    r_sck   <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx_ready      = r_txReady;
    assign o_rx_data_valid = r_rxValid;
    assign o_rx_byte       = r_rxByte;
    assign o_busy          = r_busy;
    assign o_spi_sck       = r_sck;
    assign o_spi_mosi      = r_mosi;
    assign o_spi_cs_b      = r_csB;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with short timing parameters; MISO is looped to MOSI
// or tied to a constant, and expected values are hand-computed cycle offsets and bytes.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rstB = 1'b0;
    logic       txValid = 1'b0;
    logic [7:0] txByte = 8'h00;
    logic       txLast = 1'b0;
    logic       ready, rxValid, busy, sck, mosi, csB, miso;
    logic [7:0] rxByte;
    int         misoMode = 0;

    assign miso = (misoMode == 0) ? mosi : (misoMode == 2);

    spi_master #(
        .CLKS_PER_HALF_BIT(2),
        .CS_SETUP_CLKS(2),
        .CS_HOLD_CLKS(2),
        .CS_IDLE_CLKS(4)
    ) dut (
        .i_sys_clk(clk),
        .i_rst_b(rstB),
        .i_tx_data_valid(txValid),
        .i_tx_byte(txByte),
        .i_tx_last(txLast),
        .o_tx_ready(ready),
        .o_rx_data_valid(rxValid),
        .o_rx_byte(rxByte),
        .o_busy(busy),
        .o_spi_sck(sck),
        .o_spi_mosi(mosi),
        .i_spi_miso(miso),
        .o_spi_cs_b(csB)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Bus monitor: counts SCK rises, CS releases, MOSI changes at a rise, and collects rx bytes.
    int         riseCnt = 0;
    int         csRiseCnt = 0;
    int         mosiBad = 0;
    int         acceptCnt = 0;
    logic       prevSck = 1'b0;
    logic       prevCs = 1'b1;
    logic       prevMosi = 1'b0;
    logic [7:0] rxQ[$];

    always @(negedge clk) begin
        if (sck && !prevSck) begin
            riseCnt++;
            if (mosi !== prevMosi) mosiBad++;
        end
        if (csB && !prevCs) csRiseCnt++;
        if (rxValid) rxQ.push_back(rxByte);
        prevSck = sck;
        prevCs = csB;
        prevMosi = mosi;
    end

    always @(posedge clk) begin
        if (txValid && ready) acceptCnt++;
    end

    int acceptCyc;

    task automatic applyStimulus(input logic [7:0] b, input logic l);
        int k;
        bit got;
        @(posedge clk);
        #1;
        txValid = 1'b1;
        txByte = b;
        txLast = l;
        k = 0;
        got = 1'b0;
        while (!got && k < 300) begin
            @(negedge clk);
            if (ready) begin
                got = 1'b1;
                acceptCyc = cyc;
            end
            k++;
        end
        if (!got) checkOutput("acceptTimeout", 0, 1);
        else begin
            @(posedge clk);
            #1;
        end
        txValid = 1'b0;
    endtask

    task automatic waitCycle(input int n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic waitIdle();
        int k;
        bit done;
        k = 0;
        done = 1'b0;
        while (!done && k < 300) begin
            @(negedge clk);
            if (ready && !busy) done = 1'b1;
            k++;
        end
        if (!done) checkOutput("idleTimeout", 0, 1);
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int a, g, a2, baseRise, baseCs, baseQ, baseAcc, gapBad, k;
        bit got;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstSck", sck, 0);
        checkOutput("rstMosi", mosi, 0);
        checkOutput("rstCsB", csB, 1);
        checkOutput("rstReady", ready, 0);
        checkOutput("rstRxValid", rxValid, 0);
        checkOutput("rstRxByte", rxByte, 8'h00);
        checkOutput("rstBusy", busy, 0);
        rstB = 1'b1;
        #1;
        checkOutput("readyBeforeEdge", ready, 0);
        @(negedge clk);
        checkOutput("readyAfterRelease", ready, 1);

        // Test 1: single byte 0xA5, loopback
        baseRise = riseCnt;
        applyStimulus(8'hA5, 1'b1);
        a = acceptCyc;
        waitCycle(a + 1);
        checkOutput("t1CsLow", csB, 0);
        checkOutput("t1Mosi7", mosi, 1);
        checkOutput("t1ReadyLow", ready, 0);
        checkOutput("t1Busy", busy, 1);
        waitCycle(a + 2);
        checkOutput("t1SckSetup", sck, 0);
        waitCycle(a + 3);
        checkOutput("t1FirstRise", sck, 1);
        waitCycle(a + 33);
        checkOutput("t1NoEarlyValid", rxValid, 0);
        checkOutput("t1SckFall8", sck, 0);
        waitCycle(a + 34);
        checkOutput("t1RxValid", rxValid, 1);
        checkOutput("t1RxByte", rxByte, 8'hA5);
        checkOutput("t1CsStillLow", csB, 0);
        waitCycle(a + 35);
        checkOutput("t1CsHigh", csB, 1);
        checkOutput("t1ValidPulse", rxValid, 0);
        waitCycle(a + 38);
        checkOutput("t1ReadyNotYet", ready, 0);
        waitCycle(a + 39);
        checkOutput("t1ReadyBack", ready, 1);
        checkOutput("t1BusyLow", busy, 0);
        checkOutput("t1Rises", riseCnt - baseRise, 8);

        // Test 2: burst 0x01, 0x80, 0xFF
        baseRise = riseCnt;
        baseCs = csRiseCnt;
        baseQ = rxQ.size();
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h80, 1'b0);
        applyStimulus(8'hFF, 1'b1);
        waitIdle();
        checkOutput("t2Rises", riseCnt - baseRise, 24);
        checkOutput("t2CsRises", csRiseCnt - baseCs, 1);
        checkOutput("t2RxCount", rxQ.size() - baseQ, 3);
        if (rxQ.size() >= baseQ + 3) begin
            checkOutput("t2Rx0", rxQ[baseQ], 8'h01);
            checkOutput("t2Rx1", rxQ[baseQ + 1], 8'h80);
            checkOutput("t2Rx2", rxQ[baseQ + 2], 8'hFF);
        end

        // Test 3: MISO tied low then high
        misoMode = 1;
        applyStimulus(8'hFF, 1'b1);
        waitIdle();
        checkOutput("t3Tie0", rxByte, 8'h00);
        misoMode = 2;
        applyStimulus(8'h00, 1'b1);
        waitIdle();
        checkOutput("t3Tie1", rxByte, 8'hFF);
        misoMode = 0;

        // Test 4: valid held high across a whole transfer
        baseAcc = acceptCnt;
        baseQ = rxQ.size();
        @(posedge clk);
        #1;
        txValid = 1'b1;
        txByte = 8'h5A;
        txLast = 1'b1;
        got = 1'b0;
        k = 0;
        a = 0;
        while (!got && k < 100) begin
            @(negedge clk);
            if (ready) begin
                got = 1'b1;
                a = cyc;
            end
            k++;
        end
        checkOutput("t4FirstAccept", got, 1);
        @(posedge clk);
        #1;
        got = 1'b0;
        k = 0;
        a2 = 0;
        while (!got && k < 100) begin
            @(negedge clk);
            if (ready) begin
                got = 1'b1;
                a2 = cyc;
            end
            k++;
        end
        checkOutput("t4SecondAccept", got, 1);
        checkOutput("t4AcceptGap", a2 - a, 39);
        checkOutput("t4OneAcceptSoFar", acceptCnt - baseAcc, 1);
        @(posedge clk);
        #1;
        txValid = 1'b0;
        waitIdle();
        checkOutput("t4TwoAccepts", acceptCnt - baseAcc, 2);
        checkOutput("t4RxCount", rxQ.size() - baseQ, 2);

        // Test 5: long GAP between bytes of one burst
        baseRise = riseCnt;
        baseCs = csRiseCnt;
        baseQ = rxQ.size();
        applyStimulus(8'h3A, 1'b0);
        got = 1'b0;
        k = 0;
        while (!got && k < 100) begin
            @(negedge clk);
            if (ready) got = 1'b1;
            k++;
        end
        checkOutput("t5ReachedGap", got, 1);
        gapBad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (csB !== 1'b0 || sck !== 1'b0 || ready !== 1'b1) gapBad++;
        end
        checkOutput("t5GapStable", gapBad, 0);
        applyStimulus(8'hC3, 1'b1);
        g = acceptCyc;
        waitCycle(g + 1);
        checkOutput("t5Mosi7", mosi, 1);
        waitCycle(g + 2);
        checkOutput("t5SckLowBeforeRise", sck, 0);
        waitCycle(g + 3);
        checkOutput("t5FirstRise", sck, 1);
        waitIdle();
        checkOutput("t5Rises", riseCnt - baseRise, 16);
        checkOutput("t5CsRises", csRiseCnt - baseCs, 1);
        checkOutput("t5RxCount", rxQ.size() - baseQ, 2);
        if (rxQ.size() >= baseQ + 2) begin
            checkOutput("t5Rx0", rxQ[baseQ], 8'h3A);
            checkOutput("t5Rx1", rxQ[baseQ + 1], 8'hC3);
        end

        // Test 6: reset after the third SCK rise
        baseRise = riseCnt;
        baseQ = rxQ.size();
        applyStimulus(8'h96, 1'b1);
        got = 1'b0;
        k = 0;
        while (!got && k < 100) begin
            @(negedge clk);
            if (riseCnt - baseRise >= 3) got = 1'b1;
            k++;
        end
        checkOutput("t6ThirdRise", got, 1);
        #1;
        rstB = 1'b0;
        #1;
        checkOutput("t6AsyncCsB", csB, 1);
        checkOutput("t6AsyncSck", sck, 0);
        checkOutput("t6AsyncBusy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rstB = 1'b1;
        @(negedge clk);
        checkOutput("t6ReadyAfterRelease", ready, 1);
        checkOutput("t6NoRxPulse", rxQ.size() - baseQ, 0);
        applyStimulus(8'h3C, 1'b1);
        waitIdle();
        checkOutput("t6RxCount", rxQ.size() - baseQ, 1);
        checkOutput("t6RxByte", rxByte, 8'h3C);

        checkOutput("mosiStableAtRise", mosiBad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
